sdm_cic_dec: RTL and testbench
==============================

Name: sdm_cic_dec

Overview:
- Third-order CIC decimator that directly consumes the 2-bit signed quantizer stream (qunt_out) of the sigma-delta modulator section.
- Integrates at the modulator rate, decimates by R, and differentiates at the output rate.
- Produces a multi-bit signed PCM word with a one-cycle valid strobe for the downstream FIR/compensation stage.

Parameters:
- N, 3: number of integrator/comb stages (3 in scope; generate-based).
- R, 16: decimation ratio; must be a power of two.
- LOG2R, 4: log2(R).
- W_ACC, 2+N*LOG2R (=14): internal and output word width (Hogenauer full-precision width).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- din_vld  input  1  qualifies din; one modulator sample is accepted per cycle when high.
- din  input  2  signed modulator output; legal values -2..+1, nominal stream 0/+1.
- dout  output  W_ACC  signed decimated sample.
- dout_vld  output  1  one-cycle pulse; dout is valid in that cycle.

Behaviour:
- Reset: one clock, reset is synchronous and active-high. On rising clk with rst=1, all integrators, comb delays, the phase counter, dout and dout_vld are cleared to 0. rst overrides din_vld. Reset mid-decimation-frame discards the partial frame, and the next output needs a full R samples after release.
- Input extension: din is sign-extended to W_ACC bits.
- Integrators (input rate, updated only when din_vld=1; all update simultaneously from old values):
  - i1 <= i1 + x
  - i2 <= i2 + i1
  - i3 <= i3 + i2
  - Arithmetic wraps modulo 2^W_ACC by design, with no saturation and no overflow flag.
- Phase counter cnt (LOG2R bits) increments on each accepted sample and wraps R-1 -> 0. When din_vld=1 and cnt=R-1, an internal dec_stb register is set for exactly the next cycle. din_vld=0 freezes cnt, the integrators and the strobe generation.
- Combs (output rate, evaluated in the cycle dec_stb=1, input i3):
  - c1 = i3 - d1, d1 <= i3
  - c2 = c1 - d2, d2 <= c1
  - c3 = c2 - d3, d3 <= c2
  - Subtractions are modulo 2^W_ACC. dout <= c3 and dout_vld <= 1.
- Latency: the R-th sample of a frame is accepted at edge k; the comb runs at edge k+1; dout/dout_vld are visible in the cycle after edge k+1. dout holds its value between strobes; dout_vld is 0 otherwise.
- Throughput: at most one output per R accepted samples. Strobes never occur closer than R cycles apart.
- DC gain: R^N = 4096.
  - Constant +1 gives 4096.
  - Constant -2 gives -8192, the exact minimum representable.
- Transient: outputs 1-3 after reset are settling values. From the 4th dout_vld onward, dout is exact for a constant input.
- din_vld low in the strobe-generation cycle delays the strobe until the R-th sample is actually accepted.

Decomposition:
- Shared include/package sdm_pkg holds:
  - the CIC_N and CIC_R defaults;
  - the W_ACC width function;
  - the legal-input range constants, shared with sdm_sec and its testbench.
- One natural sub-module, cic_integ: a single registered wrap-around accumulator with enable and synchronous active-high reset, instantiated N times in a generate loop. It is distinct from the existing integrator, which uses an asynchronous active-low reset.
- Combs and the phase counter stay inline.

Test Plan:
- Reset then din=0, din_vld=1 for 256 cycles -> every dout_vld pulse carries dout=0; pulses are spaced exactly 16 cycles apart.
- din=+1 constant, din_vld=1 -> first dout_vld occurs 2 cycles after the 16th sample; dout=4096 from the 4th pulse onward.
- Alternating din 1,0,1,0... -> dout=2048 from the 4th pulse onward. din=-2 constant -> dout=-8192 from the 4th pulse onward.
- din=+1 for 20000 samples, enough for the integrators to wrap repeatedly -> dout remains 4096 on every pulse after the 3rd, confirming modulo arithmetic.
- din=+1 with din_vld toggling randomly at 50% -> a pulse follows every 16 accepted samples; values are identical to the continuous-valid run, pulse-for-pulse.
- rst asserted for 1 cycle after 8 samples of frame 5 -> all outputs are 0 the next cycle; the next pulse comes only after 16 fresh samples, and the transient restarts (4096 again from the 4th pulse).

Source files
------------

// File: rtl/sdm_pkg.sv
// Shared constants for the sigma-delta section: CIC defaults, accumulator
// width helper and the legal range of the 2-bit quantizer output.
package sdm_pkg;

  localparam int CIC_N = 3;
  localparam int CIC_R = 16;

  localparam int SDM_DIN_MIN = -2;
  localparam int SDM_DIN_MAX = 1;

  // Hogenauer full-precision width for a 2-bit signed input.
  function automatic int cic_w_acc(input int n, input int r);
    return 2 + n * $clog2(r);
  endfunction

endpackage

// File: rtl/cic_integ.sv
// Single wrap-around accumulator stage of the CIC integrator chain.
// Synchronous active-high reset; updates only when enabled.
module cic_integ #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_add,
  output logic [W-1:0] o_acc
);

  logic [W-1:0] r_acc;

  always_ff @(posedge clk) begin
    if (rst)       r_acc <= '0;
    else if (i_en) r_acc <= r_acc + i_add;
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/sdm_cic_dec.sv
// Third-order CIC decimator for the 2-bit sigma-delta stream: integrate at the
// modulator rate, decimate by R, differentiate at the output rate.
module sdm_cic_dec
  import sdm_pkg::*;
#(
  parameter int N     = CIC_N,
  parameter int R     = CIC_R,
  parameter int LOG2R = $clog2(R),
  parameter int W_ACC = cic_w_acc(N, R)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_vld,
  input  logic [1:0]       din,
  output logic [W_ACC-1:0] dout,
  output logic             dout_vld
);

  logic [W_ACC-1:0]        w_x;
  logic [N:0][W_ACC-1:0]   w_int;
  logic [N:0][W_ACC-1:0]   w_c;
  logic [N-1:0][W_ACC-1:0] r_d;
  logic [LOG2R-1:0]        r_cnt;
  logic [1:0]              r_vld_pipe;
  logic                    w_frame_end;

  assign w_x      = {{(W_ACC-2){din[1]}}, din};
  assign w_int[0] = w_x;

  // Each stage adds the previous stage's registered value, so the chain
  // updates simultaneously from old values.
  for (genvar g = 0; g < N; g++) begin : g_integ
    cic_integ #(.W(W_ACC)) u_integ (
      .clk   (clk),
      .rst   (rst),
      .i_en  (din_vld),
      .i_add (w_int[g]),
      .o_acc (w_int[g+1])
    );
  end

  assign w_c[0] = w_int[N];
  for (genvar g = 0; g < N; g++) begin : g_comb
    assign w_c[g+1] = w_c[g] - r_d[g];
  end

  assign w_frame_end = din_vld && (r_cnt == LOG2R'(R - 1));

  // r_vld_pipe[0] is the decimation strobe, r_vld_pipe[1] is dout_vld.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_vld_pipe <= '0;
      r_d        <= '0;
      dout       <= '0;
    end else begin
      if (din_vld) r_cnt <= r_cnt + 1'b1;
      r_vld_pipe <= {r_vld_pipe[0], w_frame_end};
      if (r_vld_pipe[0]) begin
        r_d  <= w_c[N-1:0];
        dout <= w_c[N];
      end
    end
  end

  assign dout_vld = r_vld_pipe[1];

endmodule

// File: tb/tb_sdm_cic_dec.sv
// Scoreboard bench for sdm_cic_dec: stimulus pushes expected pulse cycle and
// value, a negedge monitor pops and compares every dout_vld pulse.
module tb_sdm_cic_dec;
  import sdm_pkg::*;

  localparam int W = cic_w_acc(CIC_N, CIC_R);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         din_vld = 1'b0;
  logic [1:0]   din = 2'b00;
  logic [W-1:0] dout;
  logic         dout_vld;

  sdm_cic_dec dut (
    .clk      (clk),
    .rst      (rst),
    .din_vld  (din_vld),
    .din      (din),
    .dout     (dout),
    .dout_vld (dout_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                  cyc;
    bit                  chk;
    logic signed [W-1:0] val;
  } exp_t;

  exp_t                sb[$];
  exp_t                m_e;
  int                  cyc = 0;
  int                  checks = 0;
  int                  failures = 0;
  int                  acc = 0;
  int                  pat = 0;
  logic signed [W-1:0] hold_ref = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // pat: 0 = zeros, 1 = +1, 2 = alternating 1/0, 3 = -2
  function automatic exp_t mk(input int p_pat, input int p, input int c);
    exp_t e;
    e.cyc = c;
    e.chk = 1'b1;
    e.val = '0;
    case (p_pat)
      0: e.val = '0;
      1: e.val = (p == 1) ? W'(560) : (p == 2) ? W'(3280) : W'(4096);
      2: begin e.chk = (p >= 4); e.val = W'(2048);  end
      default: begin e.chk = (p >= 4); e.val = W'(-8192); end
    endcase
    return e;
  endfunction

  task automatic send(input logic [1:0] x, input bit v);
    int c;
    c = cyc;
    din = x;
    din_vld = v;
    @(posedge clk); #1;
    if (v) begin
      acc++;
      if (acc % 16 == 0) sb.push_back(mk(pat, acc / 16, c + 2));
    end
  endtask

  task automatic do_reset();
    repeat (4) send(2'b00, 1'b0);
    din = 2'b01;
    din_vld = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    din_vld = 1'b0;
    acc = 0;
    hold_ref = '0;
    @(negedge clk);
    checks++;
    if (dout !== '0) begin
      failures++;
      $display("FAIL rst_dout got=%0d exp=0", $signed(dout));
    end
    checks++;
    if (dout_vld !== 1'b0) begin
      failures++;
      $display("FAIL rst_vld got=%0b exp=0", dout_vld);
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      m_e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL missed_pulse got=none exp_cycle=%0d", m_e.cyc);
    end
    if (dout_vld === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL spurious_pulse got_cycle=%0d exp=none", cyc);
      end else begin
        m_e = sb.pop_front();
        if (m_e.cyc != cyc) begin
          failures++;
          $display("FAIL pulse_cycle got=%0d exp=%0d", cyc, m_e.cyc);
        end
        if (m_e.chk) begin
          checks++;
          if (dout !== m_e.val) begin
            failures++;
            $display("FAIL pulse_value got=%0d exp=%0d", $signed(dout), m_e.val);
          end
        end
      end
      hold_ref = dout;
    end else if (!rst) begin
      checks++;
      if (dout !== hold_ref || dout_vld !== 1'b0) begin
        failures++;
        $display("FAIL dout_hold got=%0d/%0b exp=%0d/0", $signed(dout), dout_vld, hold_ref);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk); #1;

    pat = 0; do_reset();
    repeat (256) send(2'b00, 1'b1);

    pat = 1; do_reset();
    repeat (100) send(2'b01, 1'b1);

    pat = 2; do_reset();
    for (int i = 0; i < 100; i++) send((i % 2 == 0) ? 2'b01 : 2'b00, 1'b1);

    pat = 3; do_reset();
    repeat (100) send(2'b10, 1'b1);

    pat = 1; do_reset();
    for (int i = 0; i < 1000 && acc < 200; i++) send(2'b01, bit'($urandom_range(0, 1)));

    // Reset 8 samples into frame 5; transient must restart from scratch.
    pat = 1; do_reset();
    repeat (72) send(2'b01, 1'b1);
    do_reset();
    repeat (100) send(2'b01, 1'b1);

    pat = 1; do_reset();
    repeat (20000) send(2'b01, 1'b1);

    repeat (40) send(2'b00, 1'b0);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL pending_pulses got=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
